// File: rtl/adc_scheduler_pkg.sv
// adc_sched_pkg: shared FSM state encoding and default sizes for the ADC scheduler.
package adc_sched_pkg;
  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, DELIVER} state_t;
  localparam int ADC_DW = 10;
  localparam int DEF_BUSY_TIMEOUT = 8;
endpackage

// File: rtl/adc_scheduler_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req bit at or after ptr.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             valid
);
  always_comb begin
    grant = '0;
    idx = '0;
    valid = 1'b0;
    // Walk from farthest to nearest so the closest candidate overwrites the rest.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int j;
      j = (int'(ptr) + i) % N_REQ;
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = IW'(j);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/adc_scheduler.sv
// adc_scheduler: round-robin sharing of one serial ADC between N_REQ requesters,
// sequencing the converter start/done handshake and returning tagged results.
module adc_scheduler
  import adc_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW = ADC_DW,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic [DW-1:0]    result,
  output logic [IW-1:0]    result_id,
  output logic             err,
  output logic             busy,
  output logic             adc_start,
  input  logic             adc_done,
  input  logic [DW-1:0]    adc_dout
);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  state_t state, nxt;
  logic [IW-1:0] ptr, gidx, arb_idx;
  logic [N_REQ-1:0] goh, arb_oh;
  logic arb_valid, timeout;
  logic [CW-1:0] cnt;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(req),
    .ptr(ptr),
    .grant(arb_oh),
    .idx(arb_idx),
    .valid(arb_valid)
  );

  assign busy = state != IDLE;
  assign timeout = adc_done && cnt == CW'(BUSY_TIMEOUT - 1);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      nxt = (arb_valid && adc_done) ? START : IDLE;
      START:     nxt = WAIT_BUSY;
      WAIT_BUSY: nxt = !adc_done ? WAIT_DONE : timeout ? DELIVER : WAIT_BUSY;
      WAIT_DONE: nxt = adc_done ? DELIVER : WAIT_DONE;
      default:   nxt = IDLE;
    endcase
  end

  // Delivery outputs are loaded on the edge entering DELIVER so they are valid during it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= '0;
      result <= '0;
      result_id <= '0;
      err <= 1'b0;
      adc_start <= 1'b0;
      ptr <= '0;
      gidx <= '0;
      goh <= '0;
      cnt <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      unique case (state)
        IDLE: if (nxt == START) begin
          gidx <= arb_idx;
          goh <= arb_oh;
        end
        START: begin
          adc_start <= 1'b1;
          cnt <= '0;
        end
        WAIT_BUSY: begin
          if (!adc_done || timeout) adc_start <= 1'b0;
          else cnt <= cnt + 1'b1;
          if (timeout) begin
            ack <= goh;
            result_id <= gidx;
            result <= '0;
            err <= 1'b1;
          end
        end
        WAIT_DONE: if (adc_done) begin
          ack <= goh;
          result_id <= gidx;
          result <= adc_dout;
        end
        default: ptr <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_scheduler.sv
// tb_adc_scheduler: scoreboard bench with a behavioural converter model.
module tb_adc_scheduler;
  typedef struct {logic [1:0] id; logic [9:0] val; logic e;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req = '0, ack;
  logic [9:0] result, adc_dout = '0;
  logic [1:0] result_id;
  logic err, busy, adc_start, adc_done = 1'b1, start_q = 1'b0;
  int total = 0, bad = 0, rises = 0, conv_cnt = 0;
  bit stuck = 1'b0;
  logic [9:0] vals[$];
  exp_t sb[$];

  adc_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .result(result),
    .result_id(result_id), .err(err), .busy(busy), .adc_start(adc_start),
    .adc_done(adc_done), .adc_dout(adc_dout)
  );

  always #5 clk = ~clk;

  // Converter: sees start while idle, goes busy 18 clocks, then returns next queued value.
  always @(posedge clk) begin
    if (stuck) adc_done <= 1'b1;
    else if (conv_cnt > 0) begin
      conv_cnt <= conv_cnt - 1;
      if (conv_cnt == 1) adc_done <= 1'b1;
    end else if (adc_start && adc_done) begin
      adc_done <= 1'b0;
      conv_cnt <= 18;
      adc_dout <= (vals.size() > 0) ? vals.pop_front() : 10'h3FF;
    end
  end

  always @(posedge clk) begin
    start_q <= adc_start;
    if (adc_start && !start_q) rises++;
  end

  always @(negedge clk)
    if (!$onehot0(ack)) begin
      total++;
      bad++;
      $display("FAIL ack_onehot ack=%b", ack);
    end

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (|ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_conv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy && !adc_done && !adc_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ack, result, result_id, err, busy, adc_start} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {ack, result, result_id, err, busy, adc_start});
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy=%b want=0", busy);
    end
  endtask

  task automatic test_single();
    bit ok;
    exp_t e;
    int r0 = rises;
    vals.push_back(10'h2A5);
    sb.push_back(exp_t'{2'd0, 10'h2A5, 1'b0});
    req = 4'b0001;
    wait_ack(ok);
    req = '0;
    total++;
    if (!ok) begin
      bad++;
      sb.delete();
      $display("FAIL single_ack timeout got=none want=ack");
    end else begin
      e = sb.pop_front();
      if ({ack, result_id, result, err} !== {4'b1 << e.id, e.id, e.val, e.e}) begin
        bad++;
        $display("FAIL single_ack got=%b/%0d/%h/%b want=%b/%0d/%h/%b", ack, result_id, result, err, 4'b1 << e.id, e.id, e.val, e.e);
      end
    end
    @(negedge clk);
    total++;
    if (ack !== 4'b0) begin
      bad++;
      $display("FAIL single_pulse ack=%b want=0000", ack);
    end
    repeat (10) @(negedge clk);
    total++;
    if (rises - r0 !== 1) begin
      bad++;
      $display("FAIL single_starts got=%0d want=1", rises - r0);
    end
  endtask

  task automatic test_contention();
    bit ok;
    exp_t e;
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      vals.push_back(10'(k + 1));
      sb.push_back(exp_t'{2'(k % 4), 10'(k + 1), 1'b0});
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(ok);
      if (k == 4) req = '0;
      total++;
      if (!ok) begin
        bad++;
        sb.delete();
        req = '0;
        $display("FAIL contention_ack%0d timeout got=none want=ack", k);
        break;
      end
      e = sb.pop_front();
      if ({ack, result_id, result, err} !== {4'b1 << e.id, e.id, e.val, e.e}) begin
        bad++;
        $display("FAIL contention_ack%0d got=%b/%0d/%h/%b want=%b/%0d/%h/%b", k, ack, result_id, result, err, 4'b1 << e.id, e.id, e.val, e.e);
      end
      if (k < 4) begin
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL contention_gap%0d busy=%b want=0", k, busy);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL contention_restart%0d busy=%b want=1", k, busy);
        end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fairness();
    bit ok;
    exp_t e;
    vals.push_back(10'h111);
    vals.push_back(10'h222);
    vals.push_back(10'h333);
    sb.push_back(exp_t'{2'd0, 10'h111, 1'b0});
    sb.push_back(exp_t'{2'd2, 10'h222, 1'b0});
    sb.push_back(exp_t'{2'd0, 10'h333, 1'b0});
    req = 4'b0001;
    wait_conv(ok);
    req[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ack(ok);
      if (k == 1) req[2] = 1'b0;
      if (k == 2) req = '0;
      total++;
      if (!ok) begin
        bad++;
        sb.delete();
        req = '0;
        $display("FAIL fair_ack%0d timeout got=none want=ack", k);
        break;
      end
      e = sb.pop_front();
      if ({ack, result_id, result, err} !== {4'b1 << e.id, e.id, e.val, e.e}) begin
        bad++;
        $display("FAIL fair_ack%0d got=%b/%0d/%h/%b want=%b/%0d/%h/%b", k, ack, result_id, result, err, 4'b1 << e.id, e.id, e.val, e.e);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stuck();
    bit ok = 1'b0;
    int hi = 0;
    exp_t e;
    stuck = 1'b1;
    sb.push_back(exp_t'{2'd1, 10'h000, 1'b1});
    req = 4'b0010;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (adc_start) hi++;
      if (|ack) begin
        ok = 1'b1;
        break;
      end
    end
    req = '0;
    total++;
    if (hi !== 8) begin
      bad++;
      $display("FAIL stuck_start_cycles got=%0d want=8", hi);
    end
    total++;
    if (!ok) begin
      bad++;
      sb.delete();
      $display("FAIL stuck_ack timeout got=none want=ack");
    end else begin
      e = sb.pop_front();
      if ({ack, result_id, result, err} !== {4'b1 << e.id, e.id, e.val, e.e}) begin
        bad++;
        $display("FAIL stuck_ack got=%b/%0d/%h/%b want=%b/%0d/%h/%b", ack, result_id, result, err, 4'b1 << e.id, e.id, e.val, e.e);
      end
    end
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    vals.push_back(10'h155);
    sb.push_back(exp_t'{2'd1, 10'h155, 1'b0});
    req = 4'b0010;
    wait_ack(ok);
    req = '0;
    total++;
    if (!ok) begin
      bad++;
      sb.delete();
      $display("FAIL stuck_recover timeout got=none want=ack");
    end else begin
      e = sb.pop_front();
      if ({ack, result_id, result, err} !== {4'b1 << e.id, e.id, e.val, e.e}) begin
        bad++;
        $display("FAIL stuck_recover got=%b/%0d/%h/%b want=%b/%0d/%h/%b", ack, result_id, result, err, 4'b1 << e.id, e.id, e.val, e.e);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit held = 1'b1;
    exp_t e;
    vals.push_back(10'h0AA);
    req = 4'b1000;
    wait_conv(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rstmid_reach got=none want=wait_done");
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({ack, result, result_id, err, busy, adc_start} !== 19'd0) begin
      bad++;
      $display("FAIL rstmid_outputs got=%h want=0", {ack, result, result_id, err, busy, adc_start});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 40 && !adc_done; i++) begin
      @(negedge clk);
      if (!adc_done && (busy || adc_start || |ack)) held = 1'b0;
    end
    total++;
    if (held !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_hold got=granted want=idle_until_done");
    end
    vals.push_back(10'h3C3);
    sb.push_back(exp_t'{2'd3, 10'h3C3, 1'b0});
    wait_ack(ok);
    req = '0;
    total++;
    if (!ok) begin
      bad++;
      sb.delete();
      $display("FAIL rstmid_ack timeout got=none want=ack");
    end else begin
      e = sb.pop_front();
      if ({ack, result_id, result, err} !== {4'b1 << e.id, e.id, e.val, e.e}) begin
        bad++;
        $display("FAIL rstmid_ack got=%b/%0d/%h/%b want=%b/%0d/%h/%b", ack, result_id, result, err, 4'b1 << e.id, e.id, e.val, e.e);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_drop();
    bit ok;
    bit idle = 1'b1;
    exp_t e;
    int r0 = rises;
    vals.push_back(10'h2DB);
    sb.push_back(exp_t'{2'd2, 10'h2DB, 1'b0});
    req = 4'b0100;
    wait_conv(ok);
    req = '0;
    wait_ack(ok);
    total++;
    if (!ok) begin
      bad++;
      sb.delete();
      $display("FAIL drop_ack timeout got=none want=ack");
    end else begin
      e = sb.pop_front();
      if ({ack, result_id, result, err} !== {4'b1 << e.id, e.id, e.val, e.e}) begin
        bad++;
        $display("FAIL drop_ack got=%b/%0d/%h/%b want=%b/%0d/%h/%b", ack, result_id, result, err, 4'b1 << e.id, e.id, e.val, e.e);
      end
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) idle = 1'b0;
    end
    total++;
    if (!idle || rises - r0 !== 1) begin
      bad++;
      $display("FAIL drop_no_restart starts=%0d idle=%b want=1/1", rises - r0, idle);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_stuck();
    test_reset_mid();
    test_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
